// File: rtl/win_fetch_ctrl_pkg.sv
// Shared Sobel window definitions: image geometry defaults, pixel type,
// fetch FSM states and the 3x3 neighbour tap offsets (row-major, centre skipped).
// No logic; imported by the window fetch interface, controller and tap address unit.
package sobel_pkg;

  localparam int WIDTH_DEF  = 128;
  localparam int HEIGHT_DEF = 96;
  localparam int N_TAPS     = 8;

  typedef logic [7:0] pix_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

  // Tap k covers neighbour (row+TAP_DR[k], col+TAP_DC[k]).
  localparam int TAP_DR [N_TAPS] = '{-1, -1, -1,  0, 0,  1, 1, 1};
  localparam int TAP_DC [N_TAPS] = '{-1,  0,  1, -1, 1, -1, 0, 1};

  function automatic int clamp_int(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/win_fetch_ctrl_if.sv
// Bundle between scan counter, window fetch controller, image RAM and Sobel datapath.
// Ports: start/ctr_col/ctr_row request, ram_rd_en/ram_addr/ram_rdata RAM port,
// busy/win_valid/border/pix_* window result. slave = controller side, master = environment.
interface win_fetch_ctrl_if
  import sobel_pkg::*;
#(
  parameter int ADDR_W = 14
);

  logic              start;
  logic [7:0]        ctr_col;
  logic [7:0]        ctr_row;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_addr;
  pix_t              ram_rdata;
  logic              busy;
  logic              win_valid;
  logic              border;
  pix_t              pix_0, pix_1, pix_2, pix_3, pix_5, pix_6, pix_7, pix_8;

  modport slave (
    input  start, ctr_col, ctr_row, ram_rdata,
    output ram_rd_en, ram_addr, busy, win_valid, border,
    output pix_0, pix_1, pix_2, pix_3, pix_5, pix_6, pix_7, pix_8
  );

  modport master (
    output start, ctr_col, ctr_row, ram_rdata,
    input  ram_rd_en, ram_addr, busy, win_valid, border,
    input  pix_0, pix_1, pix_2, pix_3, pix_5, pix_6, pix_7, pix_8
  );

endinterface

// File: rtl/win_fetch_ctrl_tap_addr.sv
// Purpose: RAM address of one 3x3 neighbour tap around a centre pixel.
// Latency: combinational. Backpressure: none.
// Ports: i_row/i_col centre, i_tap tap index 0..7, o_addr linear RAM address.
// WIN_FETCH_REPLICATE_EDGE_EN: clamp tap row/col into the image (edge replication).
module win_tap_addr
  import sobel_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
`ifdef WIN_FETCH_REPLICATE_EDGE_EN
  parameter int HEIGHT = HEIGHT_DEF,
`endif
  parameter int ADDR_W = 14
) (
  input  logic [7:0]        i_row,
  input  logic [7:0]        i_col,
  input  logic [2:0]        i_tap,
  output logic [ADDR_W-1:0] o_addr
);

  int w_row;
  int w_col;

  always_comb begin
    w_row = int'(i_row) + TAP_DR[i_tap];
    w_col = int'(i_col) + TAP_DC[i_tap];
`ifdef WIN_FETCH_REPLICATE_EDGE_EN
    w_row = clamp_int(w_row, 0, HEIGHT - 1);
    w_col = clamp_int(w_col, 0, WIDTH - 1);
`endif
    // Only interior centres reach here without clamping, so the sum never goes negative.
    o_addr = ADDR_W'(w_row * WIDTH + w_col);
  end

endmodule

// File: rtl/win_fetch_ctrl.sv
// Purpose: sequence the eight 3x3 neighbour reads of one Sobel window over one RAM read port.
// Latency: start edge 0 -> win_valid after edge 9 (interior), after edge 0 (zero-filled border).
// Backpressure: none; start is only accepted while busy=0 (IDLE or DONE), otherwise dropped.
// Ports: clk, rst (sync, active-high), bus (slave modport: request, RAM port, window result).
// WIN_FETCH_REPLICATE_EDGE_EN: fetch border centres with clamped taps instead of zero-filling.
module win_fetch_ctrl
  import sobel_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int HEIGHT = HEIGHT_DEF,
  parameter int ADDR_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  win_fetch_ctrl_if.slave  bus
);

  fetch_state_t      r_state, w_state_nxt;
  logic [2:0]        r_tap, w_tap_nxt;
  logic [7:0]        r_row, r_col;
  logic              r_edge;
  logic              r_ram_rd_en;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_cap_vld;
  logic [2:0]        r_cap_idx;
  pix_t              r_pix [N_TAPS];
  logic              r_busy, r_win_valid, r_border;

  logic              w_can_start, w_accept, w_in_edge;
  logic [7:0]        w_src_row, w_src_col;
  logic [ADDR_W-1:0] w_tap_addr;

  assign w_can_start = (r_state == IDLE) || (r_state == DONE);
  assign w_accept    = w_can_start && bus.start;

  assign w_in_edge = (int'(bus.ctr_row) == 0) || (int'(bus.ctr_row) == HEIGHT - 1) ||
                     (int'(bus.ctr_col) == 0) || (int'(bus.ctr_col) == WIDTH - 1)  ||
                     (int'(bus.ctr_row) >= HEIGHT) || (int'(bus.ctr_col) >= WIDTH);

  // The address register is loaded with the *next* tap, so the first tap must be
  // formed from the live request coordinates before they are latched.
  assign w_src_row = w_can_start ? bus.ctr_row : r_row;
  assign w_src_col = w_can_start ? bus.ctr_col : r_col;

  win_tap_addr #(
    .WIDTH  (WIDTH),
`ifdef WIN_FETCH_REPLICATE_EDGE_EN
    .HEIGHT (HEIGHT),
`endif
    .ADDR_W (ADDR_W)
  ) u_tap_addr (
    .i_row  (w_src_row),
    .i_col  (w_src_col),
    .i_tap  (w_tap_nxt),
    .o_addr (w_tap_addr)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_tap_nxt   = r_tap;
    case (r_state)
      IDLE, DONE: begin
        w_state_nxt = IDLE;
        w_tap_nxt   = 3'd0;
        if (bus.start) begin
`ifdef WIN_FETCH_REPLICATE_EDGE_EN
          w_state_nxt = ISSUE;
`else
          w_state_nxt = w_in_edge ? DONE : ISSUE;
`endif
        end
      end
      ISSUE: begin
        w_tap_nxt = r_tap + 3'd1;
        if (r_tap == 3'd7) w_state_nxt = DRAIN;
      end
      DRAIN:   w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_tap       <= 3'd0;
      r_row       <= 8'd0;
      r_col       <= 8'd0;
      r_edge      <= 1'b0;
      r_ram_rd_en <= 1'b0;
      r_ram_addr  <= '0;
      r_cap_vld   <= 1'b0;
      r_cap_idx   <= 3'd0;
      r_busy      <= 1'b0;
      r_win_valid <= 1'b0;
      r_border    <= 1'b0;
      for (int k = 0; k < N_TAPS; k++) r_pix[k] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tap   <= w_tap_nxt;
      if (w_accept) begin
        r_row  <= bus.ctr_row;
        r_col  <= bus.ctr_col;
        r_edge <= w_in_edge;
      end

      r_ram_rd_en <= (w_state_nxt == ISSUE);
      if (w_state_nxt == ISSUE) r_ram_addr <= w_tap_addr;

      // RAM returns data one cycle after the address register, so track which tap it belongs to.
      r_cap_vld <= r_ram_rd_en;
      r_cap_idx <= r_tap;

`ifndef WIN_FETCH_REPLICATE_EDGE_EN
      if (w_accept && w_in_edge) begin
        for (int k = 0; k < N_TAPS; k++) r_pix[k] <= '0;
      end
`endif
      if (r_cap_vld) r_pix[r_cap_idx] <= bus.ram_rdata;

      r_busy      <= (w_state_nxt == ISSUE) || (w_state_nxt == DRAIN);
      r_win_valid <= (w_state_nxt == DONE);
      // border changes only together with a completed window.
      if (w_state_nxt == DONE) r_border <= (r_state == DRAIN) ? r_edge : w_in_edge;
    end
  end

  assign bus.ram_rd_en = r_ram_rd_en;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.busy      = r_busy;
  assign bus.win_valid = r_win_valid;
  assign bus.border    = r_border;
  assign bus.pix_0     = r_pix[0];
  assign bus.pix_1     = r_pix[1];
  assign bus.pix_2     = r_pix[2];
  assign bus.pix_3     = r_pix[3];
  assign bus.pix_5     = r_pix[4];
  assign bus.pix_6     = r_pix[5];
  assign bus.pix_7     = r_pix[6];
  assign bus.pix_8     = r_pix[7];

endmodule

// File: tb/tb_win_fetch_ctrl.sv
// Self-checking bench for win_fetch_ctrl: RAM preloaded with img[a] = a[7:0], 1-cycle read.
// Expected behaviour comes from a window-level model (accepted starts, tap list, latency).
// Scheduled starts drive the DUT; outputs are sampled 1 time unit after each rising edge.
module tb_win_fetch_ctrl;

  localparam int W  = 128;
  localparam int H  = 96;
  localparam int AW = 14;
  localparam int NE = 1024;
`ifdef WIN_FETCH_REPLICATE_EDGE_EN
  localparam bit REPL = 1'b1;
`else
  localparam bit REPL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  win_fetch_ctrl_if #(.ADDR_W(AW)) bus ();

  win_fetch_ctrl #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] ram_q = 8'd0;
  always @(posedge clk) if (bus.ram_rd_en) ram_q <= bus.ram_addr[7:0];
  assign bus.ram_rdata = ram_q;

  int total = 0;
  int bad   = 0;

  int s_t[$];
  int s_row[$];
  int s_col[$];
  int exp_rd[NE], exp_addr[NE], exp_busy[NE], exp_vld[NE], exp_brd[NE];
  int exp_pix[NE][8];
  int cur_pix[8];
  int cur_brd = 0;
  int g_last_addr = 0;

  task automatic chk(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic bit on_edge(input int r, input int c);
    return (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1) || (r >= H) || (c >= W);
  endfunction

  task automatic add_start(input int t, input int r, input int c);
    s_t.push_back(t);
    s_row.push_back(r);
    s_col.push_back(c);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) cur_pix[k] = 0;
    cur_brd     = 0;
    g_last_addr = 0;
  endtask

  task automatic chk_all_zero(input string tag, input int t);
    chk({tag, ".rd_en"}, t, bus.ram_rd_en, 0);
    chk({tag, ".addr"}, t, bus.ram_addr, 0);
    chk({tag, ".busy"}, t, bus.busy, 0);
    chk({tag, ".win_valid"}, t, bus.win_valid, 0);
    chk({tag, ".border"}, t, bus.border, 0);
    chk({tag, ".pix_sum"}, t, bus.pix_0 | bus.pix_1 | bus.pix_2 | bus.pix_3 |
                              bus.pix_5 | bus.pix_6 | bus.pix_7 | bus.pix_8, 0);
  endtask

  // Build the expected timeline from the scheduled starts, then drive and check edge by edge.
  task automatic run_sched(input int n);
    int nf, last, e, r, c, v, rr, cc, a, j, p;
    bit ed, fe;
    logic [7:0] obs [8];
    for (int t = 0; t < NE; t++) begin
      exp_rd[t] = 0; exp_addr[t] = 0; exp_busy[t] = 0; exp_vld[t] = 0; exp_brd[t] = 0;
      for (int k = 0; k < 8; k++) exp_pix[t][k] = 0;
    end
    nf = 0;
    for (int i = 0; i < s_t.size(); i++) begin
      e = s_t[i];
      if (e < nf) continue;
      r  = s_row[i];
      c  = s_col[i];
      ed = on_edge(r, c);
      fe = !ed || REPL;
      if (fe) begin
        j = 0;
        for (int idx = 0; idx < 9; idx++) begin
          if (idx == 4) continue;
          rr = r + idx / 3 - 1;
          cc = c + idx % 3 - 1;
          if (REPL) begin
            rr = clampi(rr, 0, H - 1);
            cc = clampi(cc, 0, W - 1);
          end
          a = rr * W + cc;
          exp_rd[e + j]      = 1;
          exp_addr[e + j]    = a;
          exp_pix[e + 9][j]  = a % 256;
          j++;
        end
        for (int k = 0; k <= 8; k++) exp_busy[e + k] = 1;
        v = e + 9;
      end else begin
        v = e;
      end
      exp_vld[v] = 1;
      exp_brd[v] = ed;
      nf = v + 1;
    end
    last = g_last_addr;
    for (int t = 0; t < NE; t++) begin
      if (exp_rd[t] != 0) last = exp_addr[t];
      else exp_addr[t] = last;
    end
    g_last_addr = last;

    p = 0;
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      if (p < s_t.size() && s_t[p] == t) begin
        bus.start   = 1'b1;
        bus.ctr_row = 8'(s_row[p]);
        bus.ctr_col = 8'(s_col[p]);
        p++;
      end else begin
        bus.start   = 1'b0;
        bus.ctr_row = 8'($urandom);
        bus.ctr_col = 8'($urandom);
      end
      @(posedge clk);
      #1;
      chk("rd_en", t, bus.ram_rd_en, exp_rd[t]);
      chk("addr", t, bus.ram_addr, exp_addr[t]);
      chk("busy", t, bus.busy, exp_busy[t]);
      chk("win_valid", t, bus.win_valid, exp_vld[t]);
      if (exp_vld[t] != 0) begin
        for (int k = 0; k < 8; k++) cur_pix[k] = exp_pix[t][k];
        cur_brd = exp_brd[t];
      end
      chk("border", t, bus.border, cur_brd);
      // pix registers fill progressively during a fetch; compare them once it has finished.
      if (exp_busy[t] == 0) begin
        obs[0] = bus.pix_0; obs[1] = bus.pix_1; obs[2] = bus.pix_2; obs[3] = bus.pix_3;
        obs[4] = bus.pix_5; obs[5] = bus.pix_6; obs[6] = bus.pix_7; obs[7] = bus.pix_8;
        for (int k = 0; k < 8; k++) chk($sformatf("pix_tap%0d", k), t, obs[k], cur_pix[k]);
      end
    end
    bus.start = 1'b0;
    s_t.delete();
    s_row.delete();
    s_col.delete();
  endtask

  initial begin
    int t, r, c;
    bus.start   = 1'b0;
    bus.ctr_row = 8'd0;
    bus.ctr_col = 8'd0;
    model_reset();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset", 0);
    @(negedge clk);
    rst = 1'b0;

    // Interior fetch, then border centres (zero-fill, or replicated fetch with the macro).
    add_start(0, 10, 20);
    add_start(12, 0, 0);
    add_start(24, 95, 127);
    add_start(36, 50, 127);
    run_sched(50);

    // Starts during a fetch are dropped; a start in the DONE cycle is taken.
    add_start(0, 10, 20);
    add_start(3, 0, 0);
    add_start(5, 40, 60);
    add_start(10, 20, 30);
    add_start(20, 1, 1);
    run_sched(34);

    // Reset in the middle of an interior fetch.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.ctr_row = 8'd10;
    bus.ctr_col = 8'd20;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      @(posedge clk);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_all_zero("midreset", 4);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      chk("post_reset.win_valid", k, bus.win_valid, 0);
      chk("post_reset.rd_en", k, bus.ram_rd_en, 0);
    end
    add_start(0, 10, 20);
    run_sched(14);

    // Random centres, including edges and out-of-range coordinates, with random spacing.
    t = 0;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0:       r = 0;
        1:       r = H - 1;
        4:       r = $urandom_range(H, 255);
        default: r = $urandom_range(1, H - 2);
      endcase
      case ($urandom_range(0, 4))
        0:       c = 0;
        1:       c = W - 1;
        4:       c = $urandom_range(W, 255);
        default: c = $urandom_range(1, W - 2);
      endcase
      add_start(t, r, c);
      t = t + $urandom_range(1, 12);
    end
    run_sched(t + 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
